// File: rtl/control_cmd_readbrightness_multi_pkg.sv
// Shared types for the control-command readers: FSM state encoding and the
// single-byte brightness level type.
package types;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_COLLECT,
        STATE_DONE
    } ctrl_readmulti_fsm_t;

    typedef logic [7:0] brightness_level_t;

endpackage

// File: rtl/control_byte_shifter.sv
// Assembles N bytes MSB-first. next_value is the stream as it would look with
// data_in shifted in now, so the owner can commit the final byte in the same
// cycle it arrives. Only the previous N-1 bytes need to be stored.
module control_byte_shifter #(
    parameter int N = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           load,
    input  logic [7:0]     data_in,
    output logic [8*N-1:0] next_value
);

    if (N == 1) begin : g_single
        assign next_value = data_in;
    end else begin : g_multi
        logic [8*N-9:0] shreg;

        assign next_value = {shreg, data_in};

        // Shadow of the most recent N-1 bytes; clear discards a partial payload
        always_ff @(posedge clk) begin
            if (reset || clear) begin
                shreg <= '0;
            end else if (load) begin
                shreg <= next_value[8*N-9:0];
            end
        end
    end

endmodule

// File: rtl/control_cmd_readbrightness_multi.sv
// Multi-channel brightness command reader: collects CHANNELS*BYTES_PER_CH
// payload bytes, clamps each channel to MAX_VALUE and commits the whole set
// with a one-cycle strobe. A stalled payload is aborted by an inter-byte timeout.
module control_cmd_readbrightness_multi
    import types::*;
#(
    parameter int                          CHANNELS       = 3,
    parameter int                          BYTES_PER_CH   = 1,
    parameter int                          TIMEOUT_CYCLES = 1024,
    parameter logic [8*BYTES_PER_CH-1:0]   MAX_VALUE      = '1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [7:0]                           data_in,
    input  logic                                 enable,
    output logic [CHANNELS*8*BYTES_PER_CH-1:0]   data_out,
    output logic                                 brightness_change_en,
    output logic                                 done,
    output logic                                 err_timeout,
    output logic                                 busy
);

    localparam int W     = 8 * BYTES_PER_CH;
    localparam int TOTAL = CHANNELS * BYTES_PER_CH;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    ctrl_readmulti_fsm_t       state, state_next;
    logic [CW-1:0]             byte_count, count_next;
    logic [TW-1:0]             timer, timer_next;
    logic                      done_next, change_next, err_next;
    logic [CHANNELS*W-1:0]     data_next;
    logic [TOTAL*8-1:0]        next_stream;
    logic [CHANNELS*W-1:0]     clamped;
    logic                      shift_load, shift_clear;

    assign shift_load  = enable && (state != STATE_DONE);
    assign shift_clear = (state == STATE_DONE);
    assign busy        = (state != STATE_IDLE);

    control_byte_shifter #(.N(TOTAL)) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .clear      (shift_clear),
        .load       (shift_load),
        .data_in    (data_in),
        .next_value (next_stream)
    );

    // Channel 0 is the first byte received, so it sits at the top of the stream
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        if (BYTES_PER_CH == 1) begin : g_level
            brightness_level_t raw;
            assign raw = next_stream[(TOTAL-1-c)*8 +: 8];
            assign clamped[c*W +: W] = (raw > MAX_VALUE) ? MAX_VALUE : raw;
        end else begin : g_wide
            logic [W-1:0] raw;
            assign raw = next_stream[(TOTAL-(c+1)*BYTES_PER_CH)*8 +: W];
            assign clamped[c*W +: W] = (raw > MAX_VALUE) ? MAX_VALUE : raw;
        end
    end

    // Next-state, counters and next registered outputs; an accepted byte always beats the timeout
    always_comb begin
        state_next  = state;
        count_next  = byte_count;
        timer_next  = timer;
        done_next   = 1'b0;
        change_next = 1'b0;
        err_next    = 1'b0;
        data_next   = '0;
        case (state)
            STATE_IDLE: begin
                if (enable) begin
                    timer_next = '0;
                    if (TOTAL == 1) begin
                        state_next  = STATE_DONE;
                        count_next  = '0;
                        done_next   = 1'b1;
                        change_next = 1'b1;
                        data_next   = clamped;
                    end else begin
                        state_next = STATE_COLLECT;
                        count_next = CW'(1);
                    end
                end
            end
            STATE_COLLECT: begin
                if (enable) begin
                    timer_next = '0;
                    if (byte_count == CW'(TOTAL - 1)) begin
                        state_next  = STATE_DONE;
                        count_next  = '0;
                        done_next   = 1'b1;
                        change_next = 1'b1;
                        data_next   = clamped;
                    end else begin
                        count_next = byte_count + CW'(1);
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST)) begin
                    state_next = STATE_DONE;
                    count_next = '0;
                    timer_next = '0;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                end else if (timer != '1) begin
                    timer_next = timer + TW'(1);
                end
            end
            STATE_DONE: begin
                state_next = STATE_IDLE;
                count_next = '0;
                timer_next = '0;
            end
            default: begin
                state_next = STATE_IDLE;
                count_next = '0;
                timer_next = '0;
            end
        endcase
    end

    // State, counters and all outputs are registered; reset discards everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= STATE_IDLE;
            byte_count           <= '0;
            timer                <= '0;
            done                 <= 1'b0;
            brightness_change_en <= 1'b0;
            err_timeout          <= 1'b0;
            data_out             <= '0;
        end else begin
            state                <= state_next;
            byte_count           <= count_next;
            timer                <= timer_next;
            done                 <= done_next;
            brightness_change_en <= change_next;
            err_timeout          <= err_next;
            data_out             <= data_next;
        end
    end

endmodule
